// File: rtl/out_uart_tx_if.sv
// Load-side and serial-side signals of the OUT-register UART. The master drives the load strobe
// and data; the slave (the UART) drives tx and status.
interface out_uart_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          out_load;
    logic [DATA_WIDTH-1:0]         out_val;
    logic                          tx;
    logic                          busy;
    logic                          overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (output out_load, out_val, input tx, busy, overflow, fifo_count);
    modport slave  (input out_load, out_val, output tx, busy, overflow, fifo_count);
endinterface

// File: rtl/out_uart_tx.sv
// OUT register serial stage: queues OUT loads in a small FIFO and sends each byte as an async
// UART frame (8N1). Defining OUT_UART_PARITY_EN adds an even-parity bit (8E1).
module out_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    out_uart_tx_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef OUT_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         baud;
    logic [IW-1:0]         bit_idx;
    logic                  tx_q, ovf_q;
    logic                  pop, push, baud_done;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted then.
    assign pop       = (state == S_IDLE) && (count != '0);
    assign push      = bus.out_load && ((count != FULL) || pop);
    assign baud_done = (baud == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.out_val;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            shreg   <= '0;
            baud    <= '0;
            bit_idx <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (bus.out_load && !push) ovf_q <= 1'b1;

            // Baud counter wraps on each bit boundary, which is also every state entry.
            baud <= baud_done ? '0 : baud + 1'b1;

            case (state)
                S_IDLE: begin
                    baud <= '0;
                    if (pop) begin
                        state <= S_START;
                        shreg <= mem[rd_ptr];
                        tx_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx_q    <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        if (bit_idx == BIT_LAST) begin
`ifdef OUT_UART_PARITY_EN
                            state <= S_PARITY;
                            tx_q  <= ^shreg;
`else
                            state <= S_STOP;
                            tx_q  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_q    <= shreg[bit_idx + 1'b1];
                        end
                    end
                end
`ifdef OUT_UART_PARITY_EN
                S_PARITY: begin
                    if (baud_done) begin
                        state <= S_STOP;
                        tx_q  <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_count = count;
    assign bus.busy       = (state != S_IDLE) || (count != '0);
endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: table-driven single frame, hand sequences for back-to-back, overflow
// and mid-frame reset, then random loads against a frame-timeline reference model.
module tb_out_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
`ifdef OUT_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;

    out_uart_tx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus();

    out_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending bytes, position inside the current frame (-1 = line idle).
    logic [7:0]  mq[$];
    logic [7:0]  acc[$];
    int          ft = -1;
    logic [10:0] frm;
    bit          movf = 0;

    logic        txlog[$];
    logic [7:0]  dec[$];
    int          starts[$];
    int          maxcnt;

    typedef struct {
        bit         load;
        logic [7:0] val;
        bit         tx;
        bit         busy;
        int         cnt;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] d);
`ifdef OUT_UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    function automatic void model_edge(input bit l, input logic [7:0] v);
        bit p;
        bit a;
        logic [7:0] d;
        p = (ft < 0) && (mq.size() > 0);
        a = l && ((mq.size() < DEPTH) || p);
        if (l && !a) movf = 1;
        if (ft >= 0) begin
            ft++;
            if (ft == FL) ft = -1;
        end
        if (p) begin
            d   = mq.pop_front();
            frm = mkframe(d);
            ft  = 0;
        end
        if (a) begin
            mq.push_back(v);
            acc.push_back(v);
        end
    endfunction

    function automatic int exp_tx();
        if (ft < 0) return 1;
        return int'(frm[ft / CPB]);
    endfunction

    task automatic cyc(input bit l, input logic [7:0] v);
        bus.out_load = l;
        bus.out_val  = v;
        @(posedge clk);
        model_edge(l, v);
        #1;
        chk("tx", int'(bus.tx), exp_tx());
        chk("fifo_count", int'(bus.fifo_count), mq.size());
        chk("busy", int'(bus.busy), int'((ft >= 0) || (mq.size() > 0)));
        chk("overflow", int'(bus.overflow), int'(movf));
        txlog.push_back(bus.tx);
        if (int'(bus.fifo_count) > maxcnt) maxcnt = int'(bus.fifo_count);
        bus.out_load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.out_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mq.delete();
        acc.delete();
        ft   = -1;
        movf = 0;
        chk("rst_tx", int'(bus.tx), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_fifo_count", int'(bus.fifo_count), 0);
        reset = 1'b1;
        txlog.delete();
        maxcnt = 0;
    endtask

    // Frames are found at idle-to-low transitions; data bits sampled mid-bit.
    function automatic void decode();
        int i;
        logic [7:0] b;
        dec.delete();
        starts.delete();
        i = 1;
        while (i < txlog.size()) begin
            if (txlog[i-1] == 1'b1 && txlog[i] == 1'b0 && (i + FL) <= txlog.size()) begin
                for (int k = 0; k < 8; k++) b[k] = txlog[i + CPB * (k + 1) + CPB / 2];
                dec.push_back(b);
                starts.push_back(i);
                i += FL;
            end else begin
                i++;
            end
        end
    endfunction

    initial begin
        int seq[NB];
        vec_t e;
        bus.out_load = 1'b0;
        bus.out_val  = '0;

`ifdef OUT_UART_PARITY_EN
        seq = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1};
`else
        seq = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1};
`endif
        e = '{load: 1'b1, val: 8'h0A, tx: 1'b1, busy: 1'b1, cnt: 1};
        tv.push_back(e);
        for (int i = 0; i < FL; i++) begin
            e = '{load: 1'b0, val: 8'h00, tx: seq[i / CPB][0], busy: 1'b1, cnt: 0};
            tv.push_back(e);
        end
        e = '{load: 1'b0, val: 8'h00, tx: 1'b1, busy: 1'b0, cnt: 0};
        tv.push_back(e);

        do_reset();

        // single byte 0x0A
        for (int i = 0; i < tv.size(); i++) begin
            cyc(tv[i].load, tv[i].val);
            chk("vec_tx", int'(bus.tx), int'(tv[i].tx));
            chk("vec_busy", int'(bus.busy), int'(tv[i].busy));
            chk("vec_count", int'(bus.fifo_count), tv[i].cnt);
        end

        // back-to-back 0x0A, 0xFF
        do_reset();
        cyc(1'b1, 8'h0A);
        cyc(1'b1, 8'hFF);
        repeat (2 * FL + 4) cyc(1'b0, 8'h00);
        decode();
        chk("b2b_frames", dec.size(), 2);
        chk("b2b_peak_count", maxcnt, 1);
        if (dec.size() >= 2) begin
            chk("b2b_byte0", int'(dec[0]), 8'h0A);
            chk("b2b_byte1", int'(dec[1]), 8'hFF);
            chk("b2b_gap", starts[1] - starts[0], FL + 1);
`ifdef OUT_UART_PARITY_EN
            chk("b2b_parity_ff", int'(txlog[starts[1] + 9 * CPB + CPB / 2]), 0);
`endif
        end

        // overflow: 6 pushes into a 4-deep FIFO
        do_reset();
        for (int v = 1; v <= 6; v++) cyc(1'b1, 8'(v));
        chk("ovf_set", int'(bus.overflow), 1);
        repeat (6 * FL) cyc(1'b0, 8'h00);
        chk("ovf_sticky", int'(bus.overflow), 1);
        decode();
        chk("ovf_frames", dec.size(), 5);
        for (int k = 0; k < 5 && k < dec.size(); k++) chk("ovf_byte", int'(dec[k]), k + 1);

        // reset during DATA of 0x55 (tx low on data bit 1)
        do_reset();
        cyc(1'b1, 8'h55);
        repeat (2 * CPB + 2) cyc(1'b0, 8'h00);
        chk("mid_pre_tx", int'(bus.tx), 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_tx", int'(bus.tx), 1);
        chk("mid_count", int'(bus.fifo_count), 0);
        chk("mid_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mq.delete();
        acc.delete();
        ft = -1;
        movf = 0;
        txlog.delete();
        repeat (2 * FL) cyc(1'b0, 8'h00);
        decode();
        chk("mid_no_frames", dec.size(), 0);

        // random loads: sparse, then dense enough to overflow
        do_reset();
        for (int i = 0; i < 300; i++) cyc($urandom_range(0, 39) == 0, 8'($urandom));
        for (int i = 0; i < 200; i++) cyc($urandom_range(0, 3) == 0, 8'($urandom));
        repeat ((DEPTH + 2) * FL) cyc(1'b0, 8'h00);
        decode();
        chk("rnd_frames", dec.size(), acc.size());
        for (int k = 0; k < dec.size() && k < acc.size(); k++) chk("rnd_byte", int'(dec[k]), int'(acc[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/out_uart_tx.md
# out_uart_tx

Serial output stage that sits directly downstream of the OUT register. Each OUT register load, issued by OUT/OUTM, pushes the value into a small FIFO. The block then transmits each queued byte as an asynchronous UART frame on a single `tx` pin, so a program's output can be observed off-chip without a display. It sits in `computer` beside `u_register_OUT`, sharing its load strobe and data bus.

## Interface
Parameters:
- `DATA_WIDTH`, from `arch_defs_pkg` (8): frame payload width.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be ≥ 2.
- `FIFO_DEPTH`, 4: queue entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserted when 0.
- `out_load`  in  1  OUT register load strobe. Sampled on `clk`; one push per high cycle.
- `out_val`  in  DATA_WIDTH  value being loaded into the OUT register.
- `tx`  out  1  serial line. Idle high.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `overflow`  out  1  sticky. Set when a push is dropped.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of queued entries.

## Operation
- Reset (while `reset`=0, asynchronous):
  - `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0.
  - FSM returns to IDLE; FIFO pointers and bit and baud counters clear.
- FIFO:
  - Circular buffer with read and write pointers, each `$clog2(FIFO_DEPTH)` bits wide. Pointers wrap modulo FIFO_DEPTH.
  - Push when `out_load`=1 and the FIFO is not full.
  - Push while full with no pop in the same cycle: the data is dropped, `overflow` is set to 1, and `fifo_count` is unchanged.
  - Push while full with a pop in the same cycle: the push is accepted and `fifo_count` stays at FIFO_DEPTH.
  - Push and pop in the same cycle when not full: `fifo_count` is unchanged.
- FSM states: IDLE, START, DATA, PARITY (compiled in only), STOP.
  - IDLE → START when `fifo_count`>0. On that transition, pop the head into the shift register and drive `tx`=0.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA: shift out LSB first, one bit per CLKS_PER_BIT cycles. A 3-bit index counts 0..DATA_WIDTH-1.
  - DATA → PARITY (if enabled) or STOP after the last data bit.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then → IDLE.
  - Back-to-back frames: IDLE lasts exactly one cycle between frames.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Resets on every state entry.
  - The state advances when the counter reaches CLKS_PER_BIT-1.
- `tx` is driven from a register (glitch-free).
- `busy` = (state≠IDLE) | (fifo_count≠0).

## Timing
- Latency from push to start bit:
  - Push is sampled at edge N. `fifo_count` becomes 1 after edge N.
  - IDLE→START at edge N+1, so `tx` falls after edge N+1.
- Frame length is CLKS_PER_BIT × 10 cycles, or × 11 with parity.
- Frame-to-frame gap: next start bit begins 1 cycle after the stop bit ends.
- Reset mid-frame: `tx` returns high immediately, regardless of clock. The partial frame and all queued data are discarded.
- `overflow` clears only on reset.

## Configuration
- Macro: `OUT_UART_PARITY_EN`.
- Defined: PARITY state is present. One even-parity bit (XOR of the data bits) is sent after the data bits. Frame is 11 bits.
- Undefined: no PARITY state. 8N1 frame of 10 bits. The FSM goes DATA→STOP directly.

## Test plan
Benches run with CLKS_PER_BIT=4 unless noted.
- Reset: hold `reset`=0 for 3 cycles, then release. Required: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0.
- Single byte: pulse `out_load` with `out_val`=0x0A for 1 cycle. Required:
  - `tx` falls one cycle later.
  - Bit sequence, each bit held 4 cycles: 0, 0,1,0,1,0,0,0,0, 1.
  - With `OUT_UART_PARITY_EN` defined: parity bit 0 inserted before the stop bit.
  - `busy` drops the cycle after the stop bit ends.
- Back-to-back: push 0x0A then 0xFF on consecutive cycles. Required:
  - `fifo_count` peaks at 1.
  - Second start bit begins exactly 1 cycle after the first stop bit ends.
  - Parity for 0xFF is 0.
  - Decoded bytes are 0x0A then 0xFF, in that order.
- Overflow: push 6 bytes (0x01..0x06) on consecutive cycles with FIFO_DEPTH=4. Required:
  - The first pop frees one slot, so 0x06 is dropped.
  - `overflow`=1 and stays set.
  - Decoded stream is 0x01..0x05.
- Reset mid-frame: assert `reset` during the DATA state of 0x55. Required: `tx`=1 within the same cycle, `fifo_count`=0, and no further frames are sent.
- System (run under `computer`): run the OUTM program to halt. Required: OUT register holds 0x0A and exactly one frame decoding to 0x0A appears on `tx`.
